// File: rtl/system_0_sysid_ext_pkg.sv
// Shared register map, control bit positions and helper functions for the
// system-ID slave; also the single source for software header generation.
package system_0_sysid_ext_pkg;

    localparam int REG_ID    = 0;
    localparam int REG_TS    = 1;
    localparam int REG_INFO  = 2;
    localparam int REG_UP_LO = 3;
    localparam int REG_UP_HI = 4;
    localparam int REG_CTRL  = 5;
    localparam int REG_SCR0  = 6;

    localparam int CTRL_CLR_BIT = 0;
    localparam int CTRL_FRZ_BIT = 1;

    localparam logic [7:0] INFO_VERSION = 8'h02;

    typedef enum logic [2:0] {
        SEL_ID,
        SEL_TS,
        SEL_INFO,
        SEL_UP_LO,
        SEL_UP_HI,
        SEL_CTRL,
        SEL_SCR,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode(input int addr, input int nscr);
        if (addr == REG_ID)    return SEL_ID;
        if (addr == REG_TS)    return SEL_TS;
        if (addr == REG_INFO)  return SEL_INFO;
        if (addr == REG_UP_LO) return SEL_UP_LO;
        if (addr == REG_UP_HI) return SEL_UP_HI;
        if (addr == REG_CTRL)  return SEL_CTRL;
        if (addr >= REG_SCR0 && addr < REG_SCR0 + nscr) return SEL_SCR;
        return SEL_NONE;
    endfunction

    function automatic logic [31:0] info_word(input int nscr, input int upw);
        return {INFO_VERSION, nscr[7:0], upw[7:0], 8'h00};
    endfunction

    // Byte-lane write: lanes with a clear enable keep their old contents.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/system_0_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID block: fixed read latency 1,
// readdatavalid, no waitrequest.
interface system_0_sysid_ext_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/system_0_sysid_uptime.sv
// Free-running uptime counter with clear/freeze and a high-word snapshot that is
// captured on the same edge the low word is read, keeping {HI,LO} coherent.
module system_0_sysid_uptime #(
    parameter int UPTIME_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                freeze,
    input  logic                snap,
    output logic [31:0]         cnt_lo,
    output logic [UPTIME_W-33:0] hi_snap
);
    localparam logic [UPTIME_W-1:0] ONE = UPTIME_W'(1);

    logic [UPTIME_W-1:0]  count;
    logic [UPTIME_W-33:0] hi_q;

    // Clear wins over freeze; the high snapshot is zeroed with the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            hi_q  <= '0;
        end else begin
            if (clr) begin
                count <= '0;
            end else if (!freeze) begin
                count <= count + ONE;
            end

            if (clr) begin
                hi_q <= '0;
            end else if (snap) begin
                hi_q <= count[UPTIME_W-1:32];
            end
        end
    end

    assign cnt_lo  = count[31:0];
    assign hi_snap = hi_q;

endmodule

// File: rtl/system_0_sysid_ext.sv
// System-ID Avalon-MM slave: ID, build timestamp, INFO, coherent 64-bit uptime,
// control (clear/freeze) and byte-writable scratch words; read latency 1.
module system_0_sysid_ext
    import system_0_sysid_ext_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter int          NUM_SCRATCH = 2,
    parameter int          UPTIME_W    = 64,
    parameter int          ADDR_W      = 4
) (
    input  logic                clock,
    input  logic                reset,
    system_0_sysid_ext_if.slave bus
);
    int                   addr_int;
    reg_sel_e             sel;
    logic                 wr_ctrl;
    logic                 clr;
    logic                 snap;
    logic                 freeze_q;
    logic [31:0]          cnt_lo;
    logic [UPTIME_W-33:0] hi_snap;
    logic [31:0]          scratch [NUM_SCRATCH];
    logic [31:0]          rd_word;
    logic [31:0]          rd_data_p1;
    logic                 vld_p1;

    assign addr_int = int'(bus.address);
    assign sel      = decode(addr_int, NUM_SCRATCH);
    assign wr_ctrl  = bus.write && (sel == SEL_CTRL);
    assign clr      = wr_ctrl && bus.writedata[CTRL_CLR_BIT];
    assign snap     = bus.read && (sel == SEL_UP_LO);

    system_0_sysid_uptime #(
        .UPTIME_W (UPTIME_W)
    ) u_uptime (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .freeze  (freeze_q),
        .snap    (snap),
        .cnt_lo  (cnt_lo),
        .hi_snap (hi_snap)
    );

    // FREEZE is taken from the same write that may also carry CLR.
    always_ff @(posedge clock) begin
        if (reset) begin
            freeze_q <= 1'b0;
        end else if (wr_ctrl) begin
            freeze_q <= bus.writedata[CTRL_FRZ_BIT];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (reset) begin
                scratch[i] <= '0;
            end else if (bus.write && addr_int == REG_SCR0 + i) begin
                scratch[i] <= lane_merge(scratch[i], bus.writedata, bus.byteenable);
            end
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write is not visible here.
    always_comb begin
        rd_word = '0;
        case (sel)
            SEL_ID:    rd_word = ID_VALUE;
            SEL_TS:    rd_word = TIMESTAMP;
            SEL_INFO:  rd_word = info_word(NUM_SCRATCH, UPTIME_W);
            SEL_UP_LO: rd_word = cnt_lo;
            SEL_UP_HI: rd_word = 32'(hi_snap);
            SEL_CTRL:  rd_word[CTRL_FRZ_BIT] = freeze_q;
            SEL_SCR: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr_int == REG_SCR0 + i) rd_word = scratch[i];
                end
            end
            default:   rd_word = '0;
        endcase
    end

    // ---- stage p1: registered read response ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= bus.read;
            if (bus.read) rd_data_p1 <= rd_word;
        end
    end

    assign bus.readdata      = rd_data_p1;
    assign bus.readdatavalid = vld_p1;

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// Bench for system_0_sysid_ext: table of register vectors plus hand sequences for
// uptime snapshot, freeze/clear, reset during a read and a 33-bit counter wrap.
module tb_system_0_sysid_ext;
    import system_0_sysid_ext_pkg::*;

    localparam logic [31:0] ID1 = 32'h6914_E027;
    localparam logic [31:0] TS1 = 32'h6650_1234;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    system_0_sysid_ext_if #(.ADDR_W(4)) b1 ();
    system_0_sysid_ext_if #(.ADDR_W(4)) b2 ();

    system_0_sysid_ext #(
        .ID_VALUE(ID1), .TIMESTAMP(TS1), .NUM_SCRATCH(2), .UPTIME_W(64), .ADDR_W(4)
    ) dut (
        .clock(clock), .reset(reset), .bus(b1)
    );

    system_0_sysid_ext #(
        .ID_VALUE(32'h0), .TIMESTAMP(32'h0), .NUM_SCRATCH(2), .UPTIME_W(33), .ADDR_W(4)
    ) dut2 (
        .clock(clock), .reset(reset), .bus(b2)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [15];
    int          checks = 0;
    int          errors = 0;
    string       tag = "init";
    logic [31:0] sb1 [$];
    logic [31:0] sb2 [$];
    logic        ev1, ev2;
    logic [31:0] hold1, hold2;
    logic [63:0] m_cnt;
    logic [31:0] m_hi;
    logic        m_frz;
    logic        rd2;
    logic [3:0]  addr2;
    logic [31:0] exp2;
    logic [31:0] frozen_lo;

    task automatic cmp_word(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s actual %08h required %08h", tag, name, act, req);
        end
    endtask

    task automatic cmp_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s actual %0b required %0b", tag, name, act, req);
        end
    endtask

    // Reference uptime behaviour for the 64-bit instance, stepped once per edge.
    task automatic model_step(input logic rst, input logic rd, input logic wr,
                              input logic [3:0] addr, input logic [31:0] wd);
        logic frz_old;
        if (rst) begin
            m_cnt = '0;
            m_hi  = '0;
            m_frz = 1'b0;
        end else begin
            frz_old = m_frz;
            if (rd && addr == 4'd3) m_hi = m_cnt[63:32];
            if (wr && addr == 4'd5) m_frz = wd[1];
            if (wr && addr == 4'd5 && wd[0]) begin
                m_cnt = '0;
                m_hi  = '0;
            end else if (!frz_old) begin
                m_cnt = m_cnt + 64'd1;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic rd, input logic wr, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        @(negedge clock);
        reset         = rst;
        b1.read       = rd;
        b1.write      = wr;
        b1.address    = addr;
        b1.writedata  = wd;
        b1.byteenable = be;
        b2.read       = rd2;
        b2.address    = addr2;
        ev1 = rd && !rst;
        ev2 = rd2 && !rst;
        if (ev1) sb1.push_back(exp);
        if (ev2) sb2.push_back(exp2);
        if (rst) begin
            hold1 = '0;
            hold2 = '0;
        end
        model_step(rst, rd, wr, addr, wd);
        @(posedge clock);
        #1;
        cmp_bit("rdv", b1.readdatavalid, ev1);
        if (b1.readdatavalid && sb1.size() > 0) begin
            hold1 = sb1.pop_front();
            cmp_word("rdata", b1.readdata, hold1);
        end else begin
            cmp_word("rdata_hold", b1.readdata, hold1);
        end
        cmp_bit("rdv33", b2.readdatavalid, ev2);
        if (b2.readdatavalid && sb2.size() > 0) begin
            hold2 = sb2.pop_front();
            cmp_word("rdata33", b2.readdata, hold2);
        end else begin
            cmp_word("rdata33_hold", b2.readdata, hold2);
        end
        rd2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic rd1(input logic [3:0] addr, input logic [31:0] exp);
        cyc(1'b0, 1'b1, 1'b0, addr, 32'h0, 4'h0, exp);
    endtask

    task automatic wr1(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] be);
        cyc(1'b0, 1'b0, 1'b1, addr, wd, be, 32'h0);
    endtask

    task automatic rd33(input logic [3:0] addr, input logic [31:0] exp);
        rd2   = 1'b1;
        addr2 = addr;
        exp2  = exp;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        b1.read = 1'b0; b1.write = 1'b0; b1.address = '0; b1.writedata = '0; b1.byteenable = '0;
        b2.read = 1'b0; b2.write = 1'b0; b2.address = '0; b2.writedata = '0; b2.byteenable = '0;
        rd2 = 1'b0; addr2 = '0; exp2 = '0;
        hold1 = '0; hold2 = '0; ev1 = 1'b0; ev2 = 1'b0;
        m_cnt = '0; m_hi = '0; m_frz = 1'b0;

        //            rd    wr    addr   wdata          be       expected read data
        tbl[0]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0,    ID1};
        tbl[1]  = '{1'b1, 1'b0, 4'd1,  32'h0,         4'h0,    TS1};
        tbl[2]  = '{1'b1, 1'b0, 4'd2,  32'h0,         4'h0,    32'h0202_4000};
        tbl[3]  = '{1'b0, 1'b1, 4'd6,  32'hA5A5_A5A5, 4'hF,    32'h0};
        tbl[4]  = '{1'b0, 1'b1, 4'd6,  32'h1234_5678, 4'b0101, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 4'd6,  32'h0,         4'h0,    32'hA534_A578};
        tbl[6]  = '{1'b0, 1'b1, 4'd0,  32'hDEAD_BEEF, 4'hF,    32'h0};
        tbl[7]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0,    ID1};
        tbl[8]  = '{1'b1, 1'b0, 4'd15, 32'h0,         4'h0,    32'h0};
        tbl[9]  = '{1'b1, 1'b1, 4'd7,  32'hFFFF_FFFF, 4'hF,    32'h0};
        tbl[10] = '{1'b1, 1'b0, 4'd7,  32'h0,         4'h0,    32'hFFFF_FFFF};
        tbl[11] = '{1'b1, 1'b1, 4'd2,  32'h1111_1111, 4'hF,    32'h0202_4000};
        tbl[12] = '{1'b1, 1'b0, 4'd5,  32'h0,         4'h0,    32'h0};
        tbl[13] = '{1'b1, 1'b1, 4'd8,  32'h7777_7777, 4'hF,    32'h0};
        tbl[14] = '{1'b1, 1'b1, 4'd7,  32'h0,         4'h0,    32'hFFFF_FFFF};

        tag = "reset";
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            tag = $sformatf("vec%0d", i);
            cyc(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].exp);
        end

        // Snapshot across a carry into bit 32.
        tag = "snapshot";
        #1 force dut.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.u_uptime.count;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        rd1(4'd3, 32'hFFFF_FFFF);
        rd1(4'd4, 32'h0);
        rd1(4'd3, m_cnt[31:0]);
        rd1(4'd4, 32'h1);

        tag = "freeze";
        cyc(1'b0, 1'b1, 1'b1, 4'd5, 32'h2, 4'hF, 32'h0);
        frozen_lo = m_cnt[31:0];
        rd1(4'd3, frozen_lo);
        idle(9);
        rd1(4'd3, frozen_lo);
        rd1(4'd5, 32'h2);

        tag = "clear";
        wr1(4'd5, 32'h1, 4'hF);
        rd1(4'd3, 32'h0);
        rd1(4'd5, 32'h0);
        rd1(4'd3, m_cnt[31:0]);
        rd1(4'd4, 32'h0);

        tag = "clr_beats_frz";
        wr1(4'd5, 32'h3, 4'hF);
        rd1(4'd3, 32'h0);
        rd1(4'd3, 32'h0);
        rd1(4'd5, 32'h2);
        wr1(4'd5, 32'h0, 4'hF);
        idle(2);
        rd1(4'd3, m_cnt[31:0]);

        tag = "reset_inflight";
        wr1(4'd6, 32'h1111_2222, 4'hF);
        rd1(4'd6, 32'h1111_2222);
        cyc(1'b1, 1'b1, 1'b0, 4'd6, 32'h0, 4'h0, 32'h1111_2222);
        rd1(4'd6, 32'h0);
        rd1(4'd7, 32'h0);
        rd1(4'd5, 32'h0);
        rd1(4'd3, m_cnt[31:0]);

        tag = "wrap33";
        #1 force dut2.u_uptime.count = 33'h1_FFFF_FFFD;
        #1 release dut2.u_uptime.count;
        rd33(4'd3, 32'hFFFF_FFFD);
        rd33(4'd4, 32'h1);
        idle(1);
        rd33(4'd3, 32'h0);
        rd33(4'd4, 32'h0);
        rd33(4'd2, 32'h0202_2100);
        rd33(4'd0, 32'h0);

        tag = "drain";
        idle(2);
        cmp_word("sb_left", 32'(sb1.size()), 32'h0);
        cmp_word("sb33_left", 32'(sb2.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
